// File: rtl/shared_mux_arb_pkg.sv
// Shared types and the wrapped priority search used by shared_mux_arbiter.
// Define SHARED_MUX_ARB_FIXED_PRIO_EN at build time for fixed-priority arbitration.
package shared_mux_arb_pkg;

    typedef enum logic {ST_IDLE, ST_BUSY} arb_state_t;

    localparam int MAX_REQ = 32;

    // First set bit of req at or above ptr, wrapping n-1 -> 0.
    function automatic int wrap_pick(
        input logic [MAX_REQ-1:0] req,
        input int                 ptr,
        input int                 n
    );
        int   pick;
        int   idx;
        logic found;
        pick  = 0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                idx = ptr + i;
                if (idx >= n) idx = idx - n;
                if (!found && req[idx[4:0]]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/shared_mux_arbiter_mux_n.sv
// Generic N:1 mux over a packed array; out-of-range selects give zero.
// Used by shared_mux_arbiter for its shared output datapath.
module mux_n #(
    parameter int N  = 4,
    parameter int W  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0][W-1:0] d,
    input  logic [SW-1:0]       sel,
    output logic [W-1:0]        y
);

    always_comb begin
        y = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SW'(i)) y = d[i];
        end
    end

endmodule

// File: rtl/shared_mux_arbiter.sv
// N-requester valid/ready arbiter sharing one mux datapath; round-robin by default,
// fixed priority (lowest index) when SHARED_MUX_ARB_FIXED_PRIO_EN is defined.
module shared_mux_arbiter
    import shared_mux_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        in_valid,
    input  logic [N_REQ-1:0][W-1:0] in_data,
    output logic [N_REQ-1:0]        in_ready,
    output logic                    out_valid,
    output logic [W-1:0]            out_data,
    output logic [IW-1:0]           out_id,
    input  logic                    out_ready
);

    arb_state_t    state, state_n;
    logic [IW-1:0] id_q, id_n, pick;
    logic [IW-1:0] rr_ptr;
    logic [W-1:0]  mux_y;

`ifdef SHARED_MUX_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [IW-1:0] rr_n;

    always_comb begin
        rr_n = rr_ptr;
        if (state == ST_BUSY && out_ready) begin
            rr_n = (id_q == IW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr <= '0;
        else     rr_ptr <= rr_n;
    end
`endif

    assign pick = IW'(wrap_pick(MAX_REQ'(in_valid), int'(rr_ptr), N_REQ));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            id_q  <= '0;
        end else begin
            state <= state_n;
            id_q  <= id_n;
        end
    end

    always_comb begin
        state_n   = state;
        id_n      = id_q;
        out_valid = 1'b0;
        in_ready  = '0;
        unique case (state)
            ST_IDLE: begin
                if (|in_valid) begin
                    state_n = ST_BUSY;
                    id_n    = pick;
                end
            end
            ST_BUSY: begin
                out_valid      = 1'b1;
                in_ready[id_q] = out_ready;
                if (out_ready) state_n = ST_IDLE;
            end
            default: ;
        endcase
        // The beat pending in a reset cycle is dropped, so nothing is offered.
        if (rst) begin
            out_valid = 1'b0;
            in_ready  = '0;
        end
    end

    assign out_id = rst ? '0 : id_q;

    mux_n #(
        .N (N_REQ),
        .W (W)
    ) u_mux (
        .d   (in_data),
        .sel (id_q),
        .y   (mux_y)
    );

    assign out_data = out_valid ? mux_y : '0;

endmodule

// File: tb/tb_shared_mux_arbiter.sv
// Self-checking bench for shared_mux_arbiter: vector table, directed sequences, random vs model.
module tb_shared_mux_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        in_valid;
    logic [N-1:0][W-1:0] in_data;
    logic [N-1:0]        in_ready;
    logic                out_valid;
    logic [W-1:0]        out_data;
    logic [IW-1:0]       out_id;
    logic                out_ready;

    int tests = 0;
    int fails = 0;

    shared_mux_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] v;
        logic         ordy;
        logic         ev;
        int           eid;
        logic [N-1:0] erdy;
        logic [W-1:0] edata;
    } vec_t;

    vec_t tbl[23];

    task automatic seq(input string nm, input logic [N-1:0] v, input int n,
                       input int ids[4], input bit do_rst);
        if (do_rst) begin
            rst = 1'b1; in_valid = '0; out_ready = 1'b1;
            tick();
            rst = 1'b0;
        end
        in_valid  = v;
        out_ready = 1'b1;
        for (int k = 0; k < 2 * n; k++) begin
            #2;
            if (k % 2 == 0) begin
                chk({nm, "_idle_valid"}, 32'(out_valid), 32'd0);
            end else begin
                chk({nm, "_valid"}, 32'(out_valid), 32'd1);
                chk({nm, "_id"}, 32'(out_id), 32'(ids[k/2]));
                chk({nm, "_ready"}, 32'(in_ready), 32'd1 << ids[k/2]);
                chk({nm, "_data"}, 32'(out_data), 32'(in_data[ids[k/2]]));
            end
            tick();
        end
    endtask

    // Transaction-level reference: current grant (-1 none), last grant, rr pointer.
    int           m_cur, m_last, m_ptr;
    logic [N-1:0] pend;
    int           age[N];

    initial begin
        int ids_a[4];
        int ids_b[4];
        logic         ev;
        int           eid;
        logic [N-1:0] erdy;
        logic [W-1:0] edata;

        in_data[0] = 8'h10; in_data[1] = 8'h21;
        in_data[2] = 8'hA5; in_data[3] = 8'h3C;

        //          rst  v        ordy ev  id erdy     data
        tbl[0]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 0, 4'b0000, 8'h00};
        tbl[1]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 0, 4'b0000, 8'h00};
        tbl[2]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 0, 4'b0000, 8'h00};
        tbl[3]  = '{1'b0, 4'b0100, 1'b1, 1'b1, 2, 4'b0100, 8'hA5};
        tbl[4]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 2, 4'b0000, 8'h00};
        tbl[5]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 2, 4'b0000, 8'h00};
        tbl[6]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 1, 4'b0000, 8'h21};
        tbl[7]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 1, 4'b0000, 8'h21};
        tbl[8]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 1, 4'b0000, 8'h21};
        tbl[9]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 1, 4'b0000, 8'h21};
        tbl[10] = '{1'b0, 4'b0010, 1'b0, 1'b1, 1, 4'b0000, 8'h21};
        tbl[11] = '{1'b0, 4'b0010, 1'b1, 1'b1, 1, 4'b0010, 8'h21};
        tbl[12] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1, 4'b0000, 8'h00};
        tbl[13] = '{1'b0, 4'b1000, 1'b1, 1'b0, 1, 4'b0000, 8'h00};
        tbl[14] = '{1'b0, 4'b1000, 1'b1, 1'b1, 3, 4'b1000, 8'h3C};
        tbl[15] = '{1'b0, 4'b1001, 1'b1, 1'b0, 3, 4'b0000, 8'h00};
        tbl[16] = '{1'b0, 4'b1001, 1'b1, 1'b1, 0, 4'b0001, 8'h10};
        tbl[17] = '{1'b0, 4'b0100, 1'b0, 1'b0, 0, 4'b0000, 8'h00};
        tbl[18] = '{1'b0, 4'b0100, 1'b0, 1'b1, 2, 4'b0000, 8'hA5};
        tbl[19] = '{1'b1, 4'b0100, 1'b1, 1'b0, 0, 4'b0000, 8'h00};
        tbl[20] = '{1'b0, 4'b0000, 1'b1, 1'b0, 0, 4'b0000, 8'h00};
        tbl[21] = '{1'b0, 4'b1111, 1'b1, 1'b0, 0, 4'b0000, 8'h00};
        tbl[22] = '{1'b0, 4'b1111, 1'b1, 1'b1, 0, 4'b0001, 8'h10};

        #1;
        for (int r = 0; r < 23; r++) begin
            rst       = tbl[r].rst;
            in_valid  = tbl[r].v;
            out_ready = tbl[r].ordy;
            #2;
            chk($sformatf("vec%0d_valid", r), 32'(out_valid), 32'(tbl[r].ev));
            chk($sformatf("vec%0d_id", r), 32'(out_id), 32'(tbl[r].eid));
            chk($sformatf("vec%0d_ready", r), 32'(in_ready), 32'(tbl[r].erdy));
            chk($sformatf("vec%0d_data", r), 32'(out_data), 32'(tbl[r].edata));
            tick();
        end

`ifdef SHARED_MUX_ARB_FIXED_PRIO_EN
        ids_a = '{0, 0, 0, 0};
        ids_b = '{1, 1, 1, 1};
`else
        ids_a = '{0, 1, 2, 3};
        ids_b = '{1, 3, 1, 3};
`endif
        seq("rr_all", 4'b1111, 4, ids_a, 1'b1);
        ids_a[0] = 0;
        seq("rr_wrap", 4'b1111, 1, ids_a, 1'b0);
        seq("macro", 4'b1010, 4, ids_b, 1'b1);
        ids_a = '{2, 0, 0, 0};
        seq("single", 4'b0100, 1, ids_a, 1'b1);
`ifdef SHARED_MUX_ARB_FIXED_PRIO_EN
        ids_a = '{0, 0, 0, 0};
`else
        ids_a = '{3, 0, 0, 0};
`endif
        seq("wrap", 4'b1001, 2, ids_a, 1'b0);

        // Random traffic against the reference model.
        rst = 1'b1; in_valid = '0; out_ready = 1'b1;
        tick();
        rst    = 1'b0;
        m_cur  = -1; m_last = 0; m_ptr = 0;
        pend   = '0;
        for (int i = 0; i < N; i++) age[i] = 0;

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i]    = 1'b1;
                    in_data[i] = W'($urandom);
                    age[i]     = 0;
                end
            end
            in_valid  = pend;
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 149) == 0);
            #2;
            ev    = (m_cur >= 0) && !rst;
            eid   = rst ? 0 : ((m_cur >= 0) ? m_cur : m_last);
            erdy  = (ev && out_ready) ? N'(1 << m_cur) : '0;
            edata = ev ? in_data[m_cur] : '0;
            chk("rnd_valid", 32'(out_valid), 32'(ev));
            chk("rnd_id", 32'(out_id), 32'(eid));
            chk("rnd_ready", 32'(in_ready), 32'(erdy));
            chk("rnd_data", 32'(out_data), 32'(edata));
            @(posedge clk);
            if (rst) begin
                m_cur = -1; m_last = 0; m_ptr = 0;
                for (int i = 0; i < N; i++) age[i] = 0;
            end else if (m_cur < 0) begin
                for (int j = N - 1; j >= 0; j--) begin
                    if (pend[(m_ptr + j) % N]) m_cur = (m_ptr + j) % N;
                end
                if (m_cur >= 0) m_last = m_cur;
            end else if (out_ready) begin
`ifndef SHARED_MUX_ARB_FIXED_PRIO_EN
                chk("rnd_starve", 32'(age[m_cur] <= N - 1), 32'd1);
                m_ptr = (m_cur + 1) % N;
`endif
                for (int i = 0; i < N; i++) begin
                    if (pend[i] && i != m_cur) age[i]++;
                end
                pend[m_cur] = 1'b0;
                m_cur = -1;
            end
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
